// File: rtl/writeback_arbiter_pkg.sv
// Shared constants, the write-back request record and a decode helper
// used by the write-back arbiter and its MDU result FIFO.
package writeback_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // One register-file write: enable, destination register, data.
  typedef struct packed {
    logic                  en;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // One-hot decode of a register address, used to build the pending mask.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = {NUM_REGS{1'b0}};
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Small in-order FIFO for MDU write-back results. Pointers carry one
// wrap bit so that full and empty are distinguishable; a per-entry
// valid/address view feeds the pending-destination mask.
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push,
  input  logic                                  pop,
  input  wb_req_t                               push_req,
  output wb_req_t                               head_req,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(DEPTH):0]                count,
  output logic [DEPTH-1:0]                      entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_req_t     mem_r [DEPTH];

  assign count    = wr_ptr_r - rd_ptr_r;
  assign full     = (count == FULL_COUNT);
  assign empty    = (wr_ptr_r == rd_ptr_r);
  assign head_req = mem_r[rd_ptr_r[AW-1:0]];

  // Storage and pointer update; pointers wrap modulo DEPTH via the low bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= push_req;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Entry i is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [AW-1:0] offset;
    offset      = {AW{1'b0}};
    entry_valid = {DEPTH{1'b0}};
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = AW'(i) - rd_ptr_r[AW-1:0];
      entry_valid[i] = ({1'b0, offset} < count);
      entry_addr[i]  = mem_r[i].addr;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the in-order MEM/WB result and buffered MDU completions onto the
// single register-file write port. The pipeline always wins; MDU results
// drain through a FIFO in idle pipeline cycles, with a stall request
// raised when the FIFO head has waited too long.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int MDU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  PIPE_WB_EN,
  input  logic [REG_ADDR_W-1:0] PIPE_WB_ADDRESS,
  input  logic [XLEN-1:0]       PIPE_WB_DATA,
  input  logic                  MDU_VALID,
  output logic                  MDU_READY,
  input  logic [REG_ADDR_W-1:0] MDU_ADDRESS,
  input  logic [XLEN-1:0]       MDU_DATA,
  output logic                  WRITE_ENABLE,
  output logic [REG_ADDR_W-1:0] WB_ADDRESS,
  output logic [XLEN-1:0]       WRITE_DATA,
  output logic [NUM_REGS-1:0]   PENDING_MASK,
  output logic                  STALL_REQ
);

  localparam int CW    = $clog2(MDU_FIFO_DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL = CW'(MDU_FIFO_DEPTH);
  localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
  localparam logic [REG_ADDR_W-1:0] X0  = REG_ADDR_W'(0);

  logic                                   pipe_req_s;
  logic                                   mdu_fire_s;
  logic                                   push_s;
  logic                                   pop_s;
  wb_req_t                                push_req_s;
  wb_req_t                                head_req_s;
  logic                                   fifo_full_s;
  logic                                   fifo_empty_s;
  logic [CW-1:0]                          fifo_count_s;
  logic [CW-1:0]                          next_count_s;
  logic [MDU_FIFO_DEPTH-1:0]              entry_valid_s;
  logic [MDU_FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_addr_s;
  logic [AGE_W-1:0]                       age_next_s;
  logic [NUM_REGS-1:0]                    mask_s;

  logic                  ready_r;
  logic                  we_r;
  logic [REG_ADDR_W-1:0] addr_r;
  logic [XLEN-1:0]       data_r;
  logic [AGE_W-1:0]      age_r;
  logic                  stall_r;

  // Writes to x0 are dropped at the source; MDU x0 results still handshake.
  assign pipe_req_s = PIPE_WB_EN && (PIPE_WB_ADDRESS != X0);
  assign mdu_fire_s = MDU_VALID && ready_r;
  assign push_s     = mdu_fire_s && (MDU_ADDRESS != X0) && !fifo_full_s;
  assign pop_s      = !pipe_req_s && !fifo_empty_s;
  assign push_req_s = '{en: 1'b1, addr: MDU_ADDRESS, data: MDU_DATA};

  wb_fifo #(
    .DEPTH (MDU_FIFO_DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst_n       (RESET),
    .push        (push_s),
    .pop         (pop_s),
    .push_req    (push_req_s),
    .head_req    (head_req_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s),
    .count       (fifo_count_s),
    .entry_valid (entry_valid_s),
    .entry_addr  (entry_addr_s)
  );

  // Occupancy after this edge; MDU_READY is registered from it.
  always_comb begin
    next_count_s = fifo_count_s;
    if (push_s) begin
      next_count_s = next_count_s + CNT_ONE;
    end else begin
      next_count_s = next_count_s;
    end
    if (pop_s) begin
      next_count_s = next_count_s - CNT_ONE;
    end else begin
      next_count_s = next_count_s;
    end
  end

  // Head age: cleared on pop or empty, otherwise counts up and saturates.
  always_comb begin
    age_next_s = age_r;
    if (fifo_empty_s || pop_s) begin
      age_next_s = {AGE_W{1'b0}};
    end else if (age_r != AGE_MAX) begin
      age_next_s = age_r + AGE_ONE;
    end else begin
      age_next_s = age_r;
    end
  end

  // Pending destinations: OR of one-hot addresses of every live FIFO entry.
  always_comb begin
    mask_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < MDU_FIFO_DEPTH; i++) begin
      if (entry_valid_s[i]) begin
        mask_s = mask_s | addr_onehot(entry_addr_s[i]);
      end else begin
        mask_s = mask_s;
      end
    end
  end

  // Arbitration, handshake ready, age and stall registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {REG_ADDR_W{1'b0}};
      data_r  <= {XLEN{1'b0}};
      age_r   <= {AGE_W{1'b0}};
      stall_r <= 1'b0;
    end else begin
      ready_r <= (next_count_s != CNT_FULL);
      age_r   <= age_next_s;
      stall_r <= (age_next_s == AGE_MAX);
      if (pipe_req_s) begin
        we_r   <= 1'b1;
        addr_r <= PIPE_WB_ADDRESS;
        data_r <= PIPE_WB_DATA;
      end else if (pop_s) begin
        we_r   <= head_req_s.en;
        addr_r <= head_req_s.addr;
        data_r <= head_req_s.data;
      end else begin
        we_r   <= 1'b0;
        addr_r <= addr_r;
        data_r <= data_r;
      end
    end
  end

  assign MDU_READY    = ready_r;
  assign WRITE_ENABLE = we_r;
  assign WB_ADDRESS   = addr_r;
  assign WRITE_DATA   = data_r;
  assign PENDING_MASK = mask_s;
  assign STALL_REQ    = stall_r;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected register-file writes are
// queued in hand-computed order as stimulus is applied; a monitor thread
// pops and compares on every observed write.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic                  CLK;
  logic                  RESET;
  logic                  PIPE_WB_EN;
  logic [REG_ADDR_W-1:0] PIPE_WB_ADDRESS;
  logic [XLEN-1:0]       PIPE_WB_DATA;
  logic                  MDU_VALID;
  logic                  MDU_READY;
  logic [REG_ADDR_W-1:0] MDU_ADDRESS;
  logic [XLEN-1:0]       MDU_DATA;
  logic                  WRITE_ENABLE;
  logic [REG_ADDR_W-1:0] WB_ADDRESS;
  logic [XLEN-1:0]       WRITE_DATA;
  logic [NUM_REGS-1:0]   PENDING_MASK;
  logic                  STALL_REQ;

  wb_req_t exp_q[$];
  int n_cmp;
  int n_err;

  writeback_arbiter #(
    .MDU_FIFO_DEPTH (2),
    .STARVE_LIMIT   (4)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PIPE_WB_EN      (PIPE_WB_EN),
    .PIPE_WB_ADDRESS (PIPE_WB_ADDRESS),
    .PIPE_WB_DATA    (PIPE_WB_DATA),
    .MDU_VALID       (MDU_VALID),
    .MDU_READY       (MDU_READY),
    .MDU_ADDRESS     (MDU_ADDRESS),
    .MDU_DATA        (MDU_DATA),
    .WRITE_ENABLE    (WRITE_ENABLE),
    .WB_ADDRESS      (WB_ADDRESS),
    .WRITE_DATA      (WRITE_DATA),
    .PENDING_MASK    (PENDING_MASK),
    .STALL_REQ       (STALL_REQ)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{en: 1'b1, addr: a, data: d});
  endtask

  task automatic pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    PIPE_WB_EN      = en;
    PIPE_WB_ADDRESS = a;
    PIPE_WB_DATA    = d;
  endtask

  task automatic mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    MDU_VALID   = v;
    MDU_ADDRESS = a;
    MDU_DATA    = d;
  endtask

  task automatic monitor();
    wb_req_t e;
    forever begin
      @(negedge CLK);
      if (WRITE_ENABLE !== 1'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got we=%b x%0d=%h, expected no write",
                   WRITE_ENABLE, WB_ADDRESS, WRITE_DATA);
        end else begin
          e = exp_q.pop_front();
          if (WRITE_ENABLE !== 1'b1 || WB_ADDRESS !== e.addr || WRITE_DATA !== e.data) begin
            n_err++;
            $display("FAIL write_order: got we=%b x%0d=%h, expected x%0d=%h",
                     WRITE_ENABLE, WB_ADDRESS, WRITE_DATA, e.addr, e.data);
          end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b0, 5'd0, 32'h0);
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    check("rst_we",    {31'd0, WRITE_ENABLE}, 32'd0);
    check("rst_addr",  {27'd0, WB_ADDRESS},   32'd0);
    check("rst_data",  WRITE_DATA,            32'd0);
    check("rst_ready", {31'd0, MDU_READY},    32'd0);
    check("rst_mask",  PENDING_MASK,          32'd0);
    check("rst_stall", {31'd0, STALL_REQ},    32'd0);
    #2 RESET = 1'b1;
    tick();
    check("ready_after_release", {31'd0, MDU_READY}, 32'd1);

    // Pipeline-only path
    pipe(1'b1, 5'd2, 32'hDEADBEEF);
    expect_write(5'd2, 32'hDEADBEEF);
    tick();
    check("pipe_addr", {27'd0, WB_ADDRESS}, 32'd2);
    check("pipe_data", WRITE_DATA, 32'hDEADBEEF);
    pipe(1'b0, 5'd0, 32'h0);

    // MDU path
    mdu(1'b1, 5'd3, 32'hCAFEBABE);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    check("mdu_mask_set", PENDING_MASK, 32'h0000_0008);
    expect_write(5'd3, 32'hCAFEBABE);
    tick();
    check("mdu_mask_clear", PENDING_MASK, 32'd0);
    tick();

    // x0 suppression
    pipe(1'b1, 5'd0, 32'h0000_1234);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b1, 5'd0, 32'h0000_0055);
    check("x0_ready", {31'd0, MDU_READY}, 32'd1);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    check("x0_mask", PENDING_MASK, 32'd0);
    check("x0_ready_after", {31'd0, MDU_READY}, 32'd1);
    tick();

    // Full FIFO and starvation
    pipe(1'b1, 5'd10, 32'hA000_0000);
    mdu(1'b1, 5'd5, 32'h1111_0001);
    expect_write(5'd10, 32'hA000_0000);
    tick();
    check("full_ready_1", {31'd0, MDU_READY}, 32'd1);
    pipe(1'b1, 5'd11, 32'hA000_0001);
    mdu(1'b1, 5'd6, 32'h1111_0002);
    expect_write(5'd11, 32'hA000_0001);
    tick();
    check("full_ready_2", {31'd0, MDU_READY}, 32'd0);
    check("full_mask", PENDING_MASK, 32'h0000_0060);
    pipe(1'b1, 5'd12, 32'hA000_0002);
    mdu(1'b1, 5'd7, 32'h1111_0003);
    expect_write(5'd12, 32'hA000_0002);
    tick();
    check("full_held", {31'd0, MDU_READY}, 32'd0);
    check("full_mask_held", PENDING_MASK, 32'h0000_0060);
    pipe(1'b1, 5'd13, 32'hA000_0003);
    expect_write(5'd13, 32'hA000_0003);
    tick();
    check("stall_not_yet", {31'd0, STALL_REQ}, 32'd0);
    pipe(1'b1, 5'd14, 32'hA000_0004);
    expect_write(5'd14, 32'hA000_0004);
    tick();
    check("stall_set", {31'd0, STALL_REQ}, 32'd1);
    pipe(1'b0, 5'd0, 32'h0);
    expect_write(5'd5, 32'h1111_0001);
    tick();
    check("stall_clear", {31'd0, STALL_REQ}, 32'd0);
    check("ready_after_pop", {31'd0, MDU_READY}, 32'd1);
    check("mask_after_pop", PENDING_MASK, 32'h0000_0040);
    expect_write(5'd6, 32'h1111_0002);
    tick();
    mdu(1'b0, 5'd0, 32'h0);
    check("mask_third", PENDING_MASK, 32'h0000_0080);
    expect_write(5'd7, 32'h1111_0003);
    tick();
    check("mask_drained", PENDING_MASK, 32'd0);
    tick();

    // Reset mid-operation with two buffered results
    pipe(1'b1, 5'd20, 32'hB000_0000);
    mdu(1'b1, 5'd8, 32'h2222_0001);
    expect_write(5'd20, 32'hB000_0000);
    tick();
    pipe(1'b1, 5'd21, 32'hB000_0001);
    mdu(1'b1, 5'd9, 32'h2222_0002);
    expect_write(5'd21, 32'hB000_0001);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    mdu(1'b0, 5'd0, 32'h0);
    check("pre_reset_mask", PENDING_MASK, 32'h0000_0300);
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    check("midrst_we",    {31'd0, WRITE_ENABLE}, 32'd0);
    check("midrst_addr",  {27'd0, WB_ADDRESS},   32'd0);
    check("midrst_data",  WRITE_DATA,            32'd0);
    check("midrst_ready", {31'd0, MDU_READY},    32'd0);
    check("midrst_mask",  PENDING_MASK,          32'd0);
    check("midrst_stall", {31'd0, STALL_REQ},    32'd0);
    @(posedge CLK);
    #3 RESET = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, MDU_READY}, 32'd1);
    check("post_rst_mask",  PENDING_MASK, 32'd0);
    tick();
    tick();
    tick();

    check("all_writes_seen", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Sits directly upstream of Register_file and drives its WRITE_ENABLE, WB_ADDRESS and WRITE_DATA inputs.
- Merges two write-back sources into the single register-file write port:
  - the in-order MEM/WB pipeline result, which has priority and is never back-pressured;
  - completions from the multi-cycle RV32M multiply/divide unit (MDU), buffered in a small FIFO behind a valid/ready handshake.
- Exports a pending-destination mask for the hazard unit and a stall request to prevent MDU starvation.

Parameters:
- MDU_FIFO_DEPTH, 2, number of buffered MDU results (power of two, at least 2).
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before STALL_REQ asserts (at least 1).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- PIPE_WB_EN  in  1  pipeline write request this cycle.
- PIPE_WB_ADDRESS  in  5  pipeline destination register.
- PIPE_WB_DATA  in  32  pipeline write data.
- MDU_VALID  in  1  MDU result available.
- MDU_READY  out  1  FIFO can accept an MDU result.
- MDU_ADDRESS  in  5  MDU destination register.
- MDU_DATA  in  32  MDU result.
- WRITE_ENABLE  out  1  register-file write enable.
- WB_ADDRESS  out  5  register-file write address.
- WRITE_DATA  out  32  register-file write data.
- PENDING_MASK  out  32  bit r is set while any valid FIFO entry targets xr.
- STALL_REQ  out  1  request to hazard unit for one pipeline write-back bubble.

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous and active-low. All state is updated on the rising edge of CLK.
- Reset values (RESET low, at any time including mid-operation):
  - WRITE_ENABLE=0, WB_ADDRESS=0, WRITE_DATA=0, STALL_REQ=0, PENDING_MASK=0, MDU_READY=0.
  - FIFO emptied; age counter cleared.
  - Buffered results are discarded; the MDU is reset by the same RESET.
- After reset release, MDU_READY rises on the first CLK edge.
- Handshake:
  - MDU transfer occurs on a rising edge with MDU_VALID and MDU_READY both high.
  - MDU_READY = !full, registered from the occupancy count.
  - A pop in the same cycle does not make room for a push when full; MDU_READY is already low and the push waits.
  - MDU_ADDRESS and MDU_DATA must be held stable while MDU_VALID is high and MDU_READY is low.
- x0 suppression:
  - A pipeline request with PIPE_WB_ADDRESS=0 is treated as no request.
  - An MDU transfer with MDU_ADDRESS=0 is accepted (handshake completes) but not enqueued.
- Arbitration, evaluated each edge:
  - If there is a pipeline request, register its address and data onto the outputs with WRITE_ENABLE=1. The FIFO is not popped.
  - Otherwise, if the FIFO is not empty, pop the head onto the outputs with WRITE_ENABLE=1.
  - Otherwise, WRITE_ENABLE=0 and WB_ADDRESS/WRITE_DATA hold their previous values.
- Latency:
  - Pipeline request to register-file write: exactly one cycle, since the outputs are registered. The hazard/forwarding unit covers this extra WB cycle.
  - MDU result to write: at least two cycles (enqueue edge, then pop edge). There is no bypass path.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Ordering:
  - FIFO is strictly in order. Wrap-around of the read and write pointers is modulo MDU_FIFO_DEPTH.
  - Occupancy is tracked with one extra bit so full and empty are unambiguous.
- PENDING_MASK:
  - Combinational OR of one-hot(address) over valid FIFO entries. Two entries to the same register set a single bit.
  - A bit clears on the edge where its last entry pops.
- Starvation:
  - The age counter increments each cycle the FIFO is non-empty and not popped. It resets to 0 on any pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - STALL_REQ = (age == STARVE_LIMIT), registered.
  - STALL_REQ stays high until the head pops. The arbiter still gives the pipeline priority; the upstream stall creates the gap.
- Same register from both sources: writes land in arbitration order. The hazard unit must use PENDING_MASK to prevent WAW reordering; the arbiter does not check for it.

Decomposition:
- Shared package:
  - XLEN=32 and REG_ADDR_W=5 constants.
  - A wb_req struct {en, addr, data} reused by the MEM/WB register and the MDU.
- One sub-module: wb_fifo, a parameterised synchronous FIFO. It provides push/pop, full/empty, and a per-entry valid/address view for PENDING_MASK.
- Arbitration, age counter and output registers stay in the top module.

Test Plan:
- Reset mid-operation:
  - Stimulus: enqueue 2 MDU results, then pull RESET low between edges.
  - Required: all outputs go to 0 immediately; after release MDU_READY=1, FIFO empty, no stale write.
- Pipeline-only path:
  - Stimulus: PIPE_WB_EN=1, PIPE_WB_ADDRESS=2, PIPE_WB_DATA=DEADBEEF.
  - Required: next edge WRITE_ENABLE=1, WB_ADDRESS=2, WRITE_DATA=DEADBEEF; Register_file reads back DEADBEEF on ADRS1=2.
- MDU path:
  - Stimulus: MDU_VALID with address 3, data CAFEBABE, pipeline idle.
  - Required: PENDING_MASK bit 3 set one cycle, register-file write of x3=CAFEBABE two cycles after the handshake, then mask returns to 0.
- Full FIFO:
  - Stimulus: 3 back-to-back MDU results while the pipeline writes every cycle.
  - Required: MDU_READY drops after 2 accepts; the third is held until a pop; writes occur in order.
- Starvation:
  - Stimulus: FIFO non-empty with continuous pipeline writes.
  - Required: STALL_REQ=1 after 4 unpopped cycles; one idle pipeline cycle pops the head and STALL_REQ returns to 0.
- x0 suppression:
  - Stimulus: pipeline write to x0 with data 1234; MDU result to x0.
  - Required: WRITE_ENABLE stays 0; the MDU handshake completes; PENDING_MASK stays 0.
